// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types for the systolic edge feeder: controller state encoding and default widths.
package systolic_skew_feeder_pkg;

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_FLUSH  = 1'b1
    } feeder_state_e;

    localparam int unsigned FEEDER_DATA_WIDTH = 32;
    localparam int unsigned FEEDER_LANES      = 4;
    localparam int unsigned FEEDER_CNT_W      = 16;

endpackage

// File: rtl/systolic_skew_feeder_skew.sv
// DEPTH-stage shift register of {valid,data}; shifts every cycle, synchronous active-low clear.
module skew_delay_line
    import systolic_skew_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FEEDER_DATA_WIDTH,
    parameter int unsigned DEPTH      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DEPTH-1:0]      r_valid;
    logic [DATA_WIDTH-1:0] r_data [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_valid[0] <= valid_i;
            r_data[0]  <= data_i;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
            end
        end
    end

    assign valid_o = r_valid[DEPTH-1];
    assign data_o  = r_data[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Edge feeder for an NxN systolic array: takes one N-lane operand vector per beat and
// emits it diagonally skewed, lane i delayed i cycles more than lane 0.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FEEDER_DATA_WIDTH,
    parameter int unsigned N          = FEEDER_LANES,
    parameter int unsigned CNT_W      = FEEDER_CNT_W
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    in_last_i,
    input  logic [N*DATA_WIDTH-1:0] in_data_i,
    output logic [N*DATA_WIDTH-1:0] lane_data_o,
    output logic [N-1:0]            lane_valid_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CNT_W-1:0]        beat_cnt_o
);

    localparam int unsigned FLUSH_W = $clog2(N) + 1;

    feeder_state_e      r_state;
    feeder_state_e      w_state_next;
    logic [FLUSH_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_busy;
    logic               w_ready;
    logic               w_accept;
    logic               w_flush_done;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_ACCEPT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_ACCEPT: if (w_accept && in_last_i) w_state_next = ST_FLUSH;
            ST_FLUSH:  if (w_flush_done)          w_state_next = ST_ACCEPT;
            default:                              w_state_next = ST_ACCEPT;
        endcase
    end

    always_comb begin
        w_ready      = (r_state == ST_ACCEPT);
        w_flush_done = (r_state == ST_FLUSH) && (r_flush_cnt == '0);
    end

    assign w_accept   = in_valid_i & w_ready;
    assign in_ready_o = w_ready;
    assign done_o     = w_flush_done;
    assign busy_o     = r_busy;
    assign beat_cnt_o = r_beat_cnt;

    // Flush length N cycles: last beat leaves lane N-1 exactly when the counter hits zero.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_flush_cnt <= '0;
            r_beat_cnt  <= '0;
            r_busy      <= 1'b0;
        end else begin
            if (w_accept && in_last_i) begin
                r_flush_cnt <= FLUSH_W'(N - 1);
            end else if ((r_state == ST_FLUSH) && !w_flush_done) begin
                r_flush_cnt <= r_flush_cnt - FLUSH_W'(1);
            end

            if (w_flush_done) begin
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end

            if (w_flush_done) begin
                r_busy <= 1'b0;
            end else if (w_accept) begin
                r_busy <= 1'b1;
            end
        end
    end

    // Non-accept cycles inject a zero bubble so the array accumulates +0.
    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] w_stage_in;

        assign w_stage_in = w_accept ? in_data_i[g*DATA_WIDTH +: DATA_WIDTH] : '0;

        skew_delay_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (g + 1)
        ) u_delay (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .valid_i (w_accept),
            .data_i  (w_stage_in),
            .valid_o (lane_valid_o[g]),
            .data_o  (lane_data_o[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: a cycle-indexed reference model queues the
// expected lane arrivals and handshake status; a negedge monitor pops and compares.
module tb_systolic_skew_feeder;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic [N*DW-1:0] in_data = '0;
    logic            in_ready;
    logic [N*DW-1:0] lane_data;
    logic [N-1:0]    lane_valid;
    logic            busy;
    logic            done;
    logic [CW-1:0]   beat_cnt;

    logic            v1 = 1'b0;
    logic            l1 = 1'b0;
    logic [DW-1:0]   d1 = '0;
    logic            rdy1;
    logic [DW-1:0]   ld1;
    logic [0:0]      lv1;
    logic            busy1;
    logic            done1;
    logic [CW-1:0]   cnt1;

    systolic_skew_feeder #(.DATA_WIDTH(DW), .N(N), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_last_i(in_last), .in_data_i(in_data), .lane_data_o(lane_data),
        .lane_valid_o(lane_valid), .busy_o(busy), .done_o(done), .beat_cnt_o(beat_cnt)
    );

    systolic_skew_feeder #(.DATA_WIDTH(DW), .N(1), .CNT_W(CW)) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(v1), .in_ready_o(rdy1),
        .in_last_i(l1), .in_data_i(d1), .lane_data_o(ld1),
        .lane_valid_o(lv1), .busy_o(busy1), .done_o(done1), .beat_cnt_o(cnt1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } lane_exp_t;

    typedef struct {
        bit          ready;
        bit          done;
        bit          busy;
        bit          chk_busy;
        logic [CW-1:0] cnt;
    } ctl_exp_t;

    lane_exp_t lane_q [N][$];
    ctl_exp_t  ctl_q [$];

    // Reference model state: operation described by beat count and the cycle its last beat was taken.
    int           m_last = -1;
    logic [CW-1:0] m_cnt = '0;
    bit           m_busy = 1'b0;

    task automatic step(input bit v, input bit l, input logic [N*DW-1:0] d, input bit rst);
        int c;
        ctl_exp_t e;
        lane_exp_t le;
        bit acc;
        @(posedge clk);
        #1;
        c = cyc;
        if (m_last >= 0 && c > m_last + N) begin
            m_last = -1;
            m_cnt  = '0;
            m_busy = 1'b0;
        end
        e.ready    = (m_last < 0);
        e.done     = (m_last >= 0) && (c == m_last + N);
        e.busy     = m_busy;
        e.chk_busy = !e.done;
        e.cnt      = m_cnt;
        ctl_q.push_back(e);

        rst_ni   = !rst;
        in_valid = v;
        in_last  = l;
        in_data  = d;

        acc = v && e.ready && !rst;
        if (acc) begin
            m_cnt  = m_cnt + 1'b1;
            m_busy = 1'b1;
            for (int i = 0; i < N; i++) begin
                le.due  = c + 1 + i;
                le.data = d[i*DW +: DW];
                lane_q[i].push_back(le);
            end
            if (l) m_last = c;
        end
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                while (lane_q[i].size() > 0 && lane_q[i][lane_q[i].size()-1].due > c)
                    void'(lane_q[i].pop_back());
            end
            m_last = -1;
            m_cnt  = '0;
            m_busy = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, rnd_vec(), 1'b0);
    endtask

    function automatic logic [N*DW-1:0] rnd_vec();
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 5))
                0:       r[i*DW +: DW] = 32'hFFFF_FFFF;
                1:       r[i*DW +: DW] = 32'h8000_0001;
                default: r[i*DW +: DW] = $urandom();
            endcase
        end
        return r;
    endfunction

    function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] x);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = x;
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        ctl_exp_t  e;
        lane_exp_t le;
        bit        ev;
        if (ctl_q.size() > 0) begin
            e = ctl_q.pop_front();
            chk("in_ready", 64'(in_ready), 64'(e.ready));
            chk("done", 64'(done), 64'(e.done));
            chk("beat_cnt", 64'(beat_cnt), 64'(e.cnt));
            if (e.chk_busy) chk("busy", 64'(busy), 64'(e.busy));
            for (int i = 0; i < N; i++) begin
                ev = (lane_q[i].size() > 0) && (lane_q[i][0].due == cyc);
                chk($sformatf("lane_valid[%0d]", i), 64'(lane_valid[i]), 64'(ev));
                if (ev) begin
                    le = lane_q[i].pop_front();
                    chk($sformatf("lane_data[%0d]", i), 64'(lane_data[i*DW +: DW]), 64'(le.data));
                end else begin
                    chk($sformatf("lane_zero[%0d]", i), 64'(lane_data[i*DW +: DW]), 64'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        // 1: single beat with last
        step(1'b1, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
        idle(N + 2);
        // 2: four back-to-back beats
        for (int k = 0; k < 4; k++) step(1'b1, k == 3, rnd_vec(), 1'b0);
        idle(N + 2);
        // 3: bubble between beats
        step(1'b1, 1'b0, rnd_vec(), 1'b0);
        step(1'b0, 1'b0, rnd_vec(), 1'b0);
        step(1'b1, 1'b1, rnd_vec(), 1'b0);
        idle(N + 2);
        // 4: valid held high through the flush window
        step(1'b1, 1'b0, rnd_vec(), 1'b0);
        step(1'b1, 1'b1, rnd_vec(), 1'b0);
        for (int k = 0; k < N + 3; k++) step(1'b1, k == N + 2, rnd_vec(), 1'b0);
        idle(N + 2);
        // 5: reset mid-operation
        step(1'b1, 1'b0, rnd_vec(), 1'b0);
        step(1'b1, 1'b0, rnd_vec(), 1'b0);
        step(1'b1, 1'b1, rnd_vec(), 1'b1);
        idle(N + 2);
        // 6: extreme data patterns
        step(1'b1, 1'b0, fill(32'hFFFF_FFFF), 1'b0);
        step(1'b1, 1'b1, fill(32'h8000_0001), 1'b0);
        idle(N + 2);
        // randomized traffic
        for (int k = 0; k < 1500; k++)
            step($urandom_range(0, 99) < 70, $urandom_range(0, 7) == 0, rnd_vec(),
                 $urandom_range(0, 299) == 0);
        idle(N + 3);
        guard = 0;
        while (ctl_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("ctl_drain", 64'(ctl_q.size()), 64'd0);
        for (int i = 0; i < N; i++) chk($sformatf("lane_drain[%0d]", i), 64'(lane_q[i].size()), 64'd0);

        // N=1 instance: beat with last emerges next cycle together with done
        @(posedge clk);
        #1;
        v1 = 1'b1;
        l1 = 1'b1;
        d1 = 32'h8000_0001;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        l1 = 1'b0;
        d1 = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("n1_lane_valid", 64'(lv1), 64'd1);
        chk("n1_lane_data", 64'(ld1), 64'h8000_0001);
        chk("n1_done", 64'(done1), 64'd1);
        chk("n1_ready_flush", 64'(rdy1), 64'd0);
        chk("n1_cnt", 64'(cnt1), 64'd1);
        @(negedge clk);
        chk("n1_ready_back", 64'(rdy1), 64'd1);
        chk("n1_done_clear", 64'(done1), 64'd0);
        chk("n1_lane_bubble", 64'(lv1), 64'd0);
        chk("n1_cnt_clear", 64'(cnt1), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
